// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch/decode instruction queue: the fetch packet, buffer
// sizing and index/count types.
package inst_buffer_pkg;

    localparam int unsigned SS_WIDTH    = 3;
    localparam int unsigned INST_BUF_SZ = 16;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [$clog2(INST_BUF_SZ)-1:0]   INST_BUF_IDX;
    typedef logic [$clog2(INST_BUF_SZ+1)-1:0] INST_BUF_CNT;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } IF_ID_PACKET;

    localparam IF_ID_PACKET NOP_PACKET = '{valid: 1'b0, inst: NOP, PC: 32'h0, NPC: 32'h0};

endpackage

// File: rtl/inst_buffer.sv
// Superscalar fetch-to-decode FIFO with squash flush and stall back-pressure.
// Define INST_BUFFER_BYPASS_EN to forward fetch packets straight to decode when empty.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = SS_WIDTH,
    parameter int unsigned DEPTH = INST_BUF_SZ
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  IF_ID_PACKET [WIDTH-1:0]          if_id_packet,
    input  logic [$clog2(WIDTH+1)-1:0]       dispatch_num,
    output logic                             stall,
    output IF_ID_PACKET [WIDTH-1:0]          id_packet,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam int unsigned NumW = $clog2(WIDTH+1);

    logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    IF_ID_PACKET     mem_q [DEPTH];

    logic            bypass;
    logic [NumW-1:0] prefix, visible, pop_num, push_num, skip, store_num, storage_pop;
    logic [WIDTH-1:0] wr_en;
    logic [IdxW-1:0] wr_addr [WIDTH];
    logic [IdxW-1:0] rd_addr [WIDTH];

    // Length of the contiguous valid run starting at slot 0.
    function automatic logic [NumW-1:0] valid_prefix(input IF_ID_PACKET [WIDTH-1:0] pkts);
        logic run;
        valid_prefix = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            run = run & pkts[i].valid;
            if (run) valid_prefix = valid_prefix + NumW'(1);
        end
    endfunction

    assign count = count_q;
    // Reserves WIDTH free slots so a full fetch group always fits.
    assign stall = count_q > CntW'(DEPTH - WIDTH);
    assign prefix = valid_prefix(if_id_packet);

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass = (count_q == '0) && !squash;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        visible = (count_q > CntW'(WIDTH)) ? NumW'(WIDTH) : NumW'(count_q);
        if (bypass) visible = prefix;

        pop_num  = '0;
        push_num = '0;
        if (!squash) begin
            pop_num = (dispatch_num > visible) ? visible : dispatch_num;
            if (!stall) push_num = prefix;
        end

        // Forwarded packets that decode consumes now never enter storage.
        skip        = bypass ? pop_num : '0;
        store_num   = push_num - skip;
        storage_pop = bypass ? '0 : pop_num;

        for (int k = 0; k < WIDTH; k++) begin
            wr_addr[k] = tail_q + IdxW'(k) - IdxW'(skip);
            wr_en[k]   = (NumW'(k) >= skip) && (NumW'(k) < push_num);
        end

        head_d  = head_q + IdxW'(storage_pop);
        tail_d  = tail_q + IdxW'(store_num);
        count_d = count_q + CntW'(store_num) - CntW'(storage_pop);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rd_addr[i]   = head_q + IdxW'(i);
            id_packet[i] = NOP_PACKET;
            if (!squash && (CntW'(i) < count_q)) begin
                id_packet[i] = mem_q[rd_addr[i]];
            end
            if (bypass && (NumW'(i) < prefix)) begin
                id_packet[i] = if_id_packet[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked by count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (wr_en[k]) mem_q[wr_addr[k]] <= if_id_packet[k];
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (WIDTH=3, DEPTH=16, default build without bypass).
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int W = 3;
    localparam int D = 16;

    logic                   clock;
    logic                   reset;
    logic                   squash;
    IF_ID_PACKET [W-1:0]    if_id_packet;
    logic [1:0]             dispatch_num;
    logic                   stall;
    IF_ID_PACKET [W-1:0]    id_packet;
    logic [4:0]             count;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: PCs expected to be held by the buffer, oldest first.
    logic [31:0] mq [$];

    inst_buffer #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .if_id_packet (if_id_packet),
        .dispatch_num (dispatch_num),
        .stall        (stall),
        .id_packet    (id_packet),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sq;
        logic [2:0]  vmask;
        logic [31:0] pc;
        logic [1:0]  disp;
        int          cnt_after;
    } vec_t;

    vec_t vecs [25];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[24:0], 7'h33};
    endfunction

    function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
        IF_ID_PACKET p;
        p.valid = v;
        p.inst  = inst_of(pc);
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive, check pre-edge outputs against the scoreboard, clock, update model.
    task automatic step(input logic sq, input logic [2:0] vmask, input logic [31:0] pc,
                        input logic [1:0] disp);
        int  n;
        logic exp_stall;
        squash       = sq;
        dispatch_num = disp;
        for (int i = 0; i < W; i++) if_id_packet[i] = mk(vmask[i], pc + 32'(4 * i));
        #3;
        exp_stall = mq.size() > (D - W);
        n = (mq.size() < W) ? mq.size() : W;
        if (!sq) assert (int'(disp) <= n) else $error("illegal dispatch_num in stimulus");
        assert (count != 5'(D)) else $error("count reached DEPTH");
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("count", 32'(count), 32'(mq.size()));
        for (int i = 0; i < W; i++) begin
            if (!sq && i < mq.size()) begin
                chk($sformatf("slot%0d_valid", i), 32'(id_packet[i].valid), 32'd1);
                chk($sformatf("slot%0d_pc", i), id_packet[i].PC, mq[i]);
                chk($sformatf("slot%0d_inst", i), id_packet[i].inst, inst_of(mq[i]));
            end else begin
                chk($sformatf("slot%0d_invalid", i), 32'(id_packet[i].valid), 32'd0);
                chk($sformatf("slot%0d_nop", i), id_packet[i].inst, NOP);
            end
        end
        @(posedge clock);
        #1;
        if (sq) begin
            mq.delete();
        end else begin
            n = (int'(disp) < mq.size()) ? int'(disp) : mq.size();
            repeat (n) void'(mq.pop_front());
            if (!exp_stall) begin
                for (int i = 0; i < W; i++) begin
                    if (!vmask[i]) break;
                    mq.push_back(pc + 32'(4 * i));
                end
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b111, 32'h000, 2'd0, 3};   // basic push
        vecs[1]  = '{1'b0, 3'b101, 32'h010, 2'd0, 4};   // gap drops slot 2
        vecs[2]  = '{1'b0, 3'b111, 32'h020, 2'd0, 7};
        vecs[3]  = '{1'b0, 3'b111, 32'h030, 2'd0, 10};
        vecs[4]  = '{1'b0, 3'b111, 32'h040, 2'd0, 13};
        vecs[5]  = '{1'b0, 3'b001, 32'h050, 2'd0, 14};
        vecs[6]  = '{1'b0, 3'b111, 32'h060, 2'd0, 14};  // stalled: no push
        vecs[7]  = '{1'b0, 3'b111, 32'h070, 2'd2, 12};  // stalled, pop 2
        vecs[8]  = '{1'b0, 3'b000, 32'h000, 2'd0, 12};  // stall released
        vecs[9]  = '{1'b0, 3'b000, 32'h000, 2'd3, 9};
        vecs[10] = '{1'b0, 3'b000, 32'h000, 2'd3, 6};
        vecs[11] = '{1'b0, 3'b000, 32'h000, 2'd3, 3};
        vecs[12] = '{1'b0, 3'b000, 32'h000, 2'd3, 0};   // head now 14
        vecs[13] = '{1'b0, 3'b111, 32'h100, 2'd0, 3};
        vecs[14] = '{1'b0, 3'b011, 32'h200, 2'd0, 5};   // storage 14,15,0,1,2
        vecs[15] = '{1'b0, 3'b000, 32'h000, 2'd3, 2};   // read across wrap
        vecs[16] = '{1'b0, 3'b000, 32'h000, 2'd2, 0};
        vecs[17] = '{1'b0, 3'b111, 32'h300, 2'd0, 3};
        vecs[18] = '{1'b0, 3'b111, 32'h310, 2'd0, 6};
        vecs[19] = '{1'b0, 3'b001, 32'h320, 2'd0, 7};
        vecs[20] = '{1'b1, 3'b111, 32'h330, 2'd3, 0};   // squash beats push/pop
        vecs[21] = '{1'b0, 3'b111, 32'h340, 2'd0, 3};
        vecs[22] = '{1'b0, 3'b000, 32'h000, 2'd1, 2};
        vecs[23] = '{1'b0, 3'b111, 32'h350, 2'd2, 3};   // simultaneous push and pop
        vecs[24] = '{1'b0, 3'b000, 32'h000, 2'd3, 0};

        reset        = 1'b1;
        squash       = 1'b0;
        dispatch_num = '0;
        for (int i = 0; i < W; i++) if_id_packet[i] = mk(1'b0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset.
        step(1'b0, 3'b000, 32'h0, 2'd0);
        chk("idle_count", 32'(count), 32'd0);

        foreach (vecs[v]) begin
            step(vecs[v].sq, vecs[v].vmask, vecs[v].pc, vecs[v].disp);
            chk($sformatf("vec%0d_count_after", v), 32'(count), 32'(vecs[v].cnt_after));
        end

        // Reset mid-stream dominates squash and a valid fetch group.
        step(1'b0, 3'b111, 32'h400, 2'd0);
        reset        = 1'b1;
        squash       = 1'b1;
        dispatch_num = 2'd0;
        for (int i = 0; i < W; i++) if_id_packet[i] = mk(1'b1, 32'h500 + 32'(4 * i));
        @(posedge clock);
        #1;
        reset  = 1'b0;
        squash = 1'b0;
        mq.delete();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);

        // After reset, first push lands at slot 0.
        step(1'b0, 3'b011, 32'h600, 2'd0);
        step(1'b0, 3'b000, 32'h000, 2'd2);
        chk("final_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
